// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared encodings for the iterative multiply/divide unit:
//               M-extension funct_3 codes, FSM state encoding and small
//               decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // M-extension funct_3 encodings
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // Control FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // Divide/remainder ops live in the upper half of the funct_3 space
    function automatic logic is_div(input logic [2:0] funct_3);
        return funct_3[2];
    endfunction

    // rs1 is treated as signed by every op except the fully unsigned ones
    function automatic logic op_signed_a(input logic [2:0] funct_3);
        return (funct_3 != MDU_MULHU) && (funct_3 != MDU_DIVU) &&
               (funct_3 != MDU_REMU);
    endfunction

    // rs2 is signed for the same ops, minus MULHSU (signed x unsigned)
    function automatic logic op_signed_b(input logic [2:0] funct_3);
        return op_signed_a(funct_3) && (funct_3 != MDU_MULHSU);
    endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sign_fix
// Description : Combinational conditional two's-complement negate. Used as
//               absolute value on operand entry and as sign restore on the
//               final product / quotient / remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] value_o
);

    // Negate when requested, otherwise pass through unchanged
    assign value_o = negate_i ? (WIDTH'(0) - value_i) : value_i;

endmodule : mdu_sign_fix
`default_nettype wire

// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iterative
// Description : Iterative RV32M/RV64M multiply/divide unit. Shift-add
//               multiply and restoring divide, one bit per cycle, behind a
//               start/busy/done handshake with pipeline flush support.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct_3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] LAST_STEP = XLEN'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t         state_q,  state_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               neg_q,    neg_d;
    logic [XLEN-1:0]    mcand_q,  mcand_d;   // |rs2|: multiplicand or divisor
    logic [2*XLEN-1:0]  prod_q,   prod_d;    // product; low half = dividend/quotient
    logic [XLEN-1:0]    rem_q,    rem_d;     // partial remainder
    logic [XLEN-1:0]    cnt_q,    cnt_d;
    logic [XLEN-1:0]    result_q, result_d;

    logic               w_sa, w_sb;
    logic [XLEN-1:0]    w_abs_a, w_abs_b;
    logic               w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0]    w_fast_res;
    logic [XLEN:0]      w_sum, w_shift, w_diff;
    logic               w_qbit;
    logic [2*XLEN-1:0]  w_mul_next, w_prod_fixed;
    logic [XLEN-1:0]    w_div_sel, w_div_fixed, w_fix_res;

    // ---------------- operand conditioning ----------------
    assign w_sa = op_signed_a(funct_3) & src_a[XLEN-1];
    assign w_sb = op_signed_b(funct_3) & src_b[XLEN-1];

    mdu_sign_fix #(.WIDTH(XLEN)) u_abs_a (
        .value_i  (src_a),
        .negate_i (w_sa),
        .value_o  (w_abs_a)
    );

    mdu_sign_fix #(.WIDTH(XLEN)) u_abs_b (
        .value_i  (src_b),
        .negate_i (w_sb),
        .value_o  (w_abs_b)
    );

    // Divide-by-zero and signed overflow have architecturally fixed results
    assign w_b_zero   = (src_b == '0);
    assign w_ovf      = ~funct_3[0] && (src_a == MIN_NEG) && (src_b == '1);
    assign w_special  = is_div(funct_3) && (w_b_zero || w_ovf);
    assign w_fast_res = w_b_zero ? (funct_3[1] ? src_a : '1)
                                 : (funct_3[1] ? '0    : src_a);

    // ---------------- iteration datapath ----------------
    // Multiply step: add multiplicand into the upper half when the LSB is set,
    // then shift the whole product right, keeping the adder carry.
    assign w_sum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    assign w_mul_next = prod_q[0] ? {w_sum, prod_q[XLEN-1:1]}
                                  : {1'b0, prod_q[2*XLEN-1:1]};

    // Divide step: shift the next dividend bit into the remainder and try a
    // subtract; a clear borrow bit means the subtract is kept.
    assign w_shift = {rem_q, prod_q[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, mcand_q};
    assign w_qbit  = ~w_diff[XLEN];

    // ---------------- result fix-up ----------------
    assign w_div_sel = funct3_q[1] ? rem_q : prod_q[XLEN-1:0];

    mdu_sign_fix #(.WIDTH(2*XLEN)) u_fix_prod (
        .value_i  (prod_q),
        .negate_i (neg_q),
        .value_o  (w_prod_fixed)
    );

    mdu_sign_fix #(.WIDTH(XLEN)) u_fix_div (
        .value_i  (w_div_sel),
        .negate_i (neg_q),
        .value_o  (w_div_fixed)
    );

    // Pick low/high product half or the signed quotient/remainder
    always_comb begin
        w_fix_res = w_div_fixed;
        case (funct3_q)
            MDU_MUL:                          w_fix_res = w_prod_fixed[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  w_fix_res = w_prod_fixed[2*XLEN-1:XLEN];
            default:                          w_fix_res = w_div_fixed;
        endcase
    end

    // ---------------- control FSM ----------------
    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    funct3_d = funct_3;
                    mcand_d  = w_abs_b;
                    prod_d   = {{XLEN{1'b0}}, w_abs_a};
                    rem_d    = '0;
                    cnt_d    = '0;
                    // Remainder follows rs1; quotient of x/0 stays all ones
                    if (!is_div(funct_3))
                        neg_d = w_sa ^ w_sb;
                    else if (funct_3[1])
                        neg_d = w_sa;
                    else
                        neg_d = (w_sa ^ w_sb) & ~w_b_zero;
                    if ((FAST_SPECIAL != 0) && w_special) begin
                        result_d = w_fast_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div(funct3_q)) begin
                        rem_d  = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                        prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], w_qbit};
                    end else begin
                        prod_d = w_mul_next;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP)
                        state_d = FIX;
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = w_fix_res;
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule : mdu_iterative
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iterative
// Description : Self-checking bench for mdu_iterative. Runs a fast-special
//               and a slow-special instance side by side on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iterative;
    import mdu_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct_3;
    logic [31:0] src_a, src_b;
    logic        busy0, done0, busy1, done1;
    logic [31:0] result0, result1;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    sb_t         q0[$];
    sb_t         q1[$];
    logic [31:0] last_res;
    vec_t        vecs[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdu_iterative #(.XLEN(XLEN), .FAST_SPECIAL(0)) dut_slow (
        .clk(clk), .reset(reset), .start(start), .funct_3(funct_3),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy0), .done(done0), .result(result0)
    );

    mdu_iterative #(.XLEN(XLEN), .FAST_SPECIAL(1)) dut_fast (
        .clk(clk), .reset(reset), .start(start), .funct_3(funct_3),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy1), .done(done1), .result(result1)
    );

    // Reference M-extension semantics
    function automatic logic [31:0] ref_mdu(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && ((b == 0) ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and retire any done pulse
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            if (done0) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL slow unexpected done: result %h at cycle %0d", result0, cyc);
                end else begin
                    sb_t e;
                    e = q0.pop_front();
                    check("slow result", result0, e.res);
                    check_int("slow done cycle", cyc, e.cyc);
                end
            end
            if (done1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL fast unexpected done: result %h at cycle %0d", result1, cyc);
                end else begin
                    sb_t e;
                    e = q1.pop_front();
                    check("fast result", result1, e.res);
                    check_int("fast done cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    // One op through both instances; poke_k>0 re-asserts start with other
    // operands for one cycle at that offset while the op is in flight
    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int poke_k);
        int l0, l1;
        sb_t e;
        l0 = XLEN + 2;
        l1 = is_special(f, a, b) ? 1 : XLEN + 2;
        funct_3 = f; src_a = a; src_b = b; start = 1'b1;
        e.res = exp; e.cyc = cyc + l0; q0.push_back(e);
        e.res = exp; e.cyc = cyc + l1; q1.push_back(e);
        for (int k = 1; k <= XLEN + 3; k++) begin
            tick();
            check("slow busy", {31'b0, busy0}, {31'b0, k < l0});
            check("fast busy", {31'b0, busy1}, {31'b0, k < l1});
            if (k == 1) start = 1'b0;
            if (poke_k > 0 && k == poke_k) begin
                start = 1'b1; funct_3 = ~f; src_a = ~a; src_b = b + 32'd3;
            end
            if (poke_k > 0 && k == poke_k + 1) start = 1'b0;
        end
        check_int("slow pending", q0.size(), 0);
        check_int("fast pending", q1.size(), 0);
        q0.delete(); q1.delete();
        last_res = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        int  acc;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs[0]  = '{MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{MDU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{MDU_DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC};
        vecs[7]  = '{MDU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[8]  = '{MDU_REMU,   32'd5,          32'd0,         32'd5};
        vecs[9]  = '{MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[10] = '{MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[11] = '{MDU_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
        vecs[12] = '{MDU_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
        vecs[13] = '{MDU_DIVU,   32'h8000_0000,  32'd0,         32'hFFFF_FFFF};
        vecs[14] = '{MDU_REMU,   32'd100,        32'd7,         32'd2};
        vecs[15] = '{MDU_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1};

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct_3 = '0; src_a = '0; src_b = '0; last_res = '0;
        repeat (3) @(negedge clk);
        check("reset slow busy",   {31'b0, busy0}, 32'd0);
        check("reset slow done",   {31'b0, done0}, 32'd0);
        check("reset slow result", result0,        32'd0);
        check("reset fast busy",   {31'b0, busy1}, 32'd0);
        check("reset fast done",   {31'b0, done1}, 32'd0);
        check("reset fast result", result1,        32'd0);
        reset = 1'b0;
        tick();

        // Directed vectors
        for (int i = 0; i < 16; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        // Random vectors against the reference model
        for (int i = 0; i < 12; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = '0;
            if (i % 5 == 1) rb = $urandom_range(1, 20);
            run_op(rf, ra, rb, ref_mdu(rf, ra, rb), 0);
        end

        // start re-asserted mid-CALC with new operands is ignored
        run_op(MDU_DIV, 32'd1000, 32'd7, 32'd142, 5);

        // Start held high across DONE: second op accepted only in next IDLE
        acc = cyc;
        funct_3 = MDU_MUL; src_a = 32'd12; src_b = 32'd11; start = 1'b1;
        e.res = 32'd132; e.cyc = acc + XLEN + 2;
        q0.push_back(e); q1.push_back(e);
        for (int k = 1; k <= 2 * XLEN + 6; k++) begin
            tick();
            if (k == 1) begin
                src_a = 32'd9; src_b = 32'd13;
                e.res = 32'd117; e.cyc = acc + 2 * XLEN + 5;
                q0.push_back(e); q1.push_back(e);
            end
            if (k == XLEN + 4) start = 1'b0;
        end
        check_int("b2b slow pending", q0.size(), 0);
        check_int("b2b fast pending", q1.size(), 0);
        q0.delete(); q1.delete();
        last_res = 32'd117;

        // flush in cycle 10 of a DIV
        funct_3 = MDU_DIV; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (k == 10) flush = 1'b1;
        end
        tick();
        flush = 1'b0;
        check("flush slow busy", {31'b0, busy0}, 32'd0);
        check("flush fast busy", {31'b0, busy1}, 32'd0);
        // flush together with start in IDLE: no acceptance
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        tick();
        check("flush+start slow busy", {31'b0, busy0}, 32'd0);
        check("flush+start fast busy", {31'b0, busy1}, 32'd0);
        repeat (XLEN + 8) tick();
        check("flush slow result held", result0, last_res);
        check("flush fast result held", result1, last_res);

        // Async reset pulse mid-CALC
        funct_3 = MDU_MUL; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        check("areset slow busy",   {31'b0, busy0}, 32'd0);
        check("areset slow done",   {31'b0, done0}, 32'd0);
        check("areset slow result", result0,        32'd0);
        check("areset fast busy",   {31'b0, busy1}, 32'd0);
        check("areset fast result", result1,        32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_op(MDU_MUL, 32'd5, 32'd6, 32'd30, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mdu_iterative
`default_nettype wire
